// File: rtl/keypad_pkg.sv
// Shared key codes, scanner state type and the keypad matrix key map.
package keypad_pkg;

  localparam logic [3:0] KEY_NOKEY = 4'd10;
  localparam logic [3:0] KEY_STAR  = 4'd11;
  localparam logic [3:0] KEY_HASH  = 4'd12;

  typedef enum logic [1:0] {
    SCAN        = 2'd0,
    DEB_PRESS   = 2'd1,
    PRESSED     = 2'd2,
    DEB_RELEASE = 2'd3
  } state_e;

  // Rows 0-2 hold digits 1-9 in reading order; row 3 is '*', '0', '#'.
  function automatic logic [3:0] code(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] k;
    if (row == 2'd3) begin
      case (col)
        2'd0:    k = KEY_STAR;
        2'd1:    k = 4'd0;
        default: k = KEY_HASH;
      endcase
    end else begin
      k = {2'b00, row} * 4'd3 + {2'b00, col} + 4'd1;
    end
    return k;
  endfunction

endpackage

// File: rtl/keypad_scanner_sync.sv
// Two-flop synchroniser for asynchronous inputs; resets to all ones (idle rows).
module sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= '1;
      r_sync <= '1;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/keypad_scanner.sv
// 4x3 matrix keypad scanner with press/release debounce and a press strobe.
// Define KEYPAD_STAR_HASH_EN to report '*' (11) and '#' (12); otherwise both are ignored.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV        = 16,
  parameter int unsigned DEBOUNCE_CYCLES = 1000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [3:0] row_in,
  output logic [2:0] col_drive,
  output logic [3:0] key,
  output logic       key_pulse
);

  localparam int unsigned SLOT_W = $clog2(SCAN_DIV);
  localparam int unsigned DEB_W  = $clog2(DEBOUNCE_CYCLES);

  logic [3:0]        w_rs;
  state_e            r_state;
  state_e            w_next;
  logic [1:0]        r_col;
  logic [1:0]        r_row;
  logic [SLOT_W-1:0] r_slot;
  logic [DEB_W-1:0]  r_deb;
  logic              r_accept;
  logic [3:0]        r_key;
  logic              r_pulse;

  logic [3:0]        w_row_mask;
  logic              w_hit;
  logic [1:0]        w_hit_row;
  logic              w_row_low;
  logic              w_slot_end;
  logic              w_deb_done;
  logic [1:0]        w_col_inc;
  logic              w_accept;

  sync_2ff #(.WIDTH(4)) u_row_sync (
    .i_clk   (clock),
    .i_rst_n (reset_n),
    .i_d     (row_in),
    .o_q     (w_rs)
  );

  always_comb begin
`ifdef KEYPAD_STAR_HASH_EN
    w_row_mask = ~w_rs;
`else
    // Row 3 only carries a usable key ('0') in column 1.
    w_row_mask = ~w_rs & ((r_col == 2'd1) ? 4'b1111 : 4'b0111);
`endif
    w_hit     = |w_row_mask;
    w_hit_row = '0;
    for (int unsigned i = 4; i > 0; i--) begin
      if (w_row_mask[i-1]) w_hit_row = 2'(i - 1);
    end
  end

  assign w_row_low  = ~w_rs[r_row];
  assign w_slot_end = (r_slot == SLOT_W'(SCAN_DIV - 1));
  assign w_deb_done = (r_deb == DEB_W'(DEBOUNCE_CYCLES - 1));
  assign w_col_inc  = (r_col == 2'd2) ? 2'd0 : r_col + 2'd1;
  assign w_accept   = (r_state == DEB_PRESS) && w_row_low && w_deb_done;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= SCAN;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      SCAN:        if (w_slot_end && w_hit) w_next = DEB_PRESS;
      DEB_PRESS:   if (!w_row_low) w_next = SCAN;
                   else if (w_deb_done) w_next = PRESSED;
      PRESSED:     if (!w_row_low) w_next = DEB_RELEASE;
      DEB_RELEASE: if (w_row_low) w_next = PRESSED;
                   else if (w_deb_done) w_next = SCAN;
      default:     w_next = SCAN;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_col    <= '0;
      r_row    <= '0;
      r_slot   <= '0;
      r_deb    <= '0;
      r_accept <= 1'b0;
      r_key    <= KEY_NOKEY;
      r_pulse  <= 1'b0;
    end else begin
      // Key load is delayed one cycle behind the PRESSED entry.
      r_accept <= w_accept;
      r_pulse  <= r_accept;
      if (r_accept) r_key <= code(r_row, r_col);
      case (r_state)
        SCAN: begin
          if (w_slot_end) begin
            r_slot <= '0;
            if (w_hit) begin
              r_row <= w_hit_row;
              r_deb <= '0;
            end else begin
              r_col <= w_col_inc;
            end
          end else begin
            r_slot <= r_slot + SLOT_W'(1);
          end
        end
        DEB_PRESS: begin
          if (!w_row_low) begin
            r_col  <= w_col_inc;
            r_slot <= '0;
          end else if (!w_deb_done) begin
            r_deb <= r_deb + DEB_W'(1);
          end
        end
        PRESSED: r_deb <= '0;
        DEB_RELEASE: begin
          if (w_row_low) begin
            r_deb <= '0;
          end else if (w_deb_done) begin
            r_col  <= '0;
            r_slot <= '0;
            r_key  <= KEY_NOKEY;
          end else begin
            r_deb <= r_deb + DEB_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign col_drive = ~(3'b001 << r_col);
  assign key       = r_key;
  assign key_pulse = r_pulse;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a physical keypad model gates rows by the driven column.
module tb_keypad_scanner;

  localparam int SCAN_DIV = 4;
  localparam int DEB      = 8;
`ifdef KEYPAD_STAR_HASH_EN
  localparam bit STAR_EN = 1'b1;
`else
  localparam bit STAR_EN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  row_in;
  logic [2:0]  col_drive;
  logic [3:0]  key;
  logic        key_pulse;
  logic [11:0] pressed = '0;

  int n_checks = 0;
  int n_pass   = 0;

  // Key labels in matrix order (index = row*3 + col); 11 = '*', 12 = '#'.
  int LAYOUT [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 11, 0, 12};

  keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_CYCLES(DEB)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .row_in    (row_in),
    .col_drive (col_drive),
    .key       (key),
    .key_pulse (key_pulse)
  );

  always #5 clock = ~clock;

  always_comb begin
    row_in = '1;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 3; c++)
        if (pressed[r*3+c] && !col_drive[c]) row_in[r] = 1'b0;
  end

  function automatic int exp_key(int idx);
    int k;
    k = LAYOUT[idx];
    if (k > 9 && !STAR_EN) return 10;
    return k;
  endfunction

  function automatic int col_of_key(int k);
    for (int i = 0; i < 12; i++) if (LAYOUT[i] == k) return i % 3;
    return -1;
  endfunction

  function automatic logic [2:0] col_pat(int c);
    logic [2:0] p;
    p = 3'b111;
    p[c] = 1'b0;
    return p;
  endfunction

  task automatic pulse_reset();
    @(negedge clock);
    reset_n = 1'b0;
    pressed = '0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
  endtask

  // Holds the given keys and reports what the outputs did meanwhile.
  task automatic press_hold(input logic [11:0] mask, input int cycles, output int pulses,
                            output int final_key, output bit unstable, output bit col_bad);
    int held;
    int c;
    bit prev_pulse;
    pressed = mask;
    pulses = 0; held = 10; unstable = 0; col_bad = 0; prev_pulse = 0;
    repeat (cycles) begin
      @(negedge clock);
      if (key_pulse) begin
        pulses++;
        if (prev_pulse) unstable = 1;
      end
      prev_pulse = key_pulse;
      if (key != 4'd10) begin
        if (held == 10) held = int'(key);
        else if (int'(key) != held) unstable = 1;
        c = col_of_key(int'(key));
        if (c < 0 || col_drive !== col_pat(c)) col_bad = 1;
      end else if (held != 10) begin
        unstable = 1;
      end
    end
    final_key = int'(key);
  endtask

  task automatic release_wait(output int latency, output logic [2:0] col_at, output int pulses);
    pressed = '0;
    latency = -1; col_at = 3'bxxx; pulses = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clock);
      if (key_pulse) pulses++;
      if (key == 4'd10) begin
        latency = i;
        col_at = col_drive;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int col;
    @(negedge clock);
    reset_n = 1'b0;
    pressed = '0;
    #1;
    n_checks++;
    if (key !== 4'd10 || key_pulse !== 1'b0 || col_drive !== 3'b110)
      $display("FAIL reset_state: key=%0d pulse=%b col=%b, expected key=10 pulse=0 col=110",
               key, key_pulse, col_drive);
    else n_pass++;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    for (int k = 1; k <= 9 * SCAN_DIV; k++) begin
      @(negedge clock);
      col = (k / SCAN_DIV) % 3;
      n_checks++;
      if (col_drive !== col_pat(col) || key !== 4'd10 || key_pulse !== 1'b0)
        $display("FAIL idle_scan[%0d]: col=%b key=%0d pulse=%b, expected col=%b key=10 pulse=0",
                 k, col_drive, key, key_pulse, col_pat(col));
      else n_pass++;
    end
  endtask

  task automatic test_press_latency();
    bit found;
    int lat, relp, ek, ep;
    logic [2:0] col_at;
    int want;
    pulse_reset();
    pressed = 12'b1 << 4;
    want = exp_key(4);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clock);
      if (col_drive == 3'b101) found = 1;
    end
    n_checks++;
    if (!found) $display("FAIL press_col1_reached: col=%b, expected 101 within 20 cycles", col_drive);
    else n_pass++;
    if (found) begin
      for (int k = 1; k <= 50; k++) begin
        @(negedge clock);
        ek = (k >= SCAN_DIV + DEB + 1) ? want : 10;
        ep = (k == SCAN_DIV + DEB + 1) ? 1 : 0;
        n_checks++;
        if (int'(key) != ek || int'(key_pulse) != ep || col_drive !== 3'b101)
          $display("FAIL press_latency[%0d]: key=%0d pulse=%b col=%b, expected key=%0d pulse=%0d col=101",
                   k, key, key_pulse, col_drive, ek, ep);
        else n_pass++;
      end
    end
    release_wait(lat, col_at, relp);
    n_checks++;
    if (lat < 0 || col_at !== 3'b110 || relp != 0)
      $display("FAIL press_release: latency=%0d col=%b pulses=%0d, expected key=10 with col=110 and no pulse",
               lat, col_at, relp);
    else n_pass++;
  endtask

  task automatic test_bounce();
    logic [11:0] pat;
    bit found, bad;
    logic [2:0] seen;
    pat = 12'b0011_1001_1111;
    pulse_reset();
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clock);
      if (col_drive == 3'b011) found = 1;
    end
    n_checks++;
    if (!found) $display("FAIL bounce_col2_reached: col=%b, expected 011 within 20 cycles", col_drive);
    else n_pass++;
    for (int i = 0; i < 12; i++) begin
      pressed = pat[i] ? (12'b1 << 2) : 12'b0;
      @(negedge clock);
      n_checks++;
      if (key !== 4'd10 || key_pulse !== 1'b0)
        $display("FAIL bounce[%0d]: key=%0d pulse=%b, expected key=10 pulse=0", i, key, key_pulse);
      else n_pass++;
    end
    pressed = '0;
    bad = 0; seen = '0;
    repeat (9 * SCAN_DIV) begin
      @(negedge clock);
      if (key !== 4'd10 || key_pulse !== 1'b0) bad = 1;
      for (int c = 0; c < 3; c++) if (col_drive == col_pat(c)) seen[c] = 1'b1;
    end
    n_checks++;
    if (bad || seen != 3'b111)
      $display("FAIL bounce_resume: output_change=%0d cols_seen=%b, expected 0 and 111", bad, seen);
    else n_pass++;
  endtask

  task automatic test_release_glitch();
    int pulses, fk, lat, relp;
    bit unst, colb, bad;
    logic [2:0] col_at;
    pulse_reset();
    press_hold(12'b1 << 7, 40, pulses, fk, unst, colb);
    n_checks++;
    if (fk != exp_key(7) || pulses != 1 || unst || colb)
      $display("FAIL glitch_press: key=%0d pulses=%0d unstable=%0d colbad=%0d, expected key=%0d pulses=1 0 0",
               fk, pulses, unst, colb, exp_key(7));
    else n_pass++;
    pressed = '0;
    bad = 0;
    repeat (4) begin
      @(negedge clock);
      if (int'(key) != exp_key(7) || key_pulse) bad = 1;
    end
    press_hold(12'b1 << 7, 30, pulses, fk, unst, colb);
    n_checks++;
    if (bad || fk != exp_key(7) || pulses != 0 || unst || colb)
      $display("FAIL glitch_hold: key=%0d pulses=%0d gap_bad=%0d unstable=%0d, expected key=%0d pulses=0",
               fk, pulses, bad, unst, exp_key(7));
    else n_pass++;
    release_wait(lat, col_at, relp);
    n_checks++;
    if (lat < DEB || lat > DEB + 4 || col_at !== 3'b110 || relp != 0)
      $display("FAIL glitch_release: latency=%0d col=%b pulses=%0d, expected latency %0d..%0d col=110 no pulse",
               lat, col_at, relp, DEB, DEB + 4);
    else n_pass++;
  endtask

  task automatic test_star_hash();
    int pulses, fk, lat, relp, ek;
    bit unst, colb;
    logic [2:0] col_at;
    int idxs [2] = '{9, 11};
    pulse_reset();
    foreach (idxs[j]) begin
      ek = exp_key(idxs[j]);
      press_hold(12'b1 << idxs[j], 60, pulses, fk, unst, colb);
      n_checks++;
      if (fk != ek || pulses != ((ek != 10) ? 1 : 0) || unst || colb)
        $display("FAIL star_hash[%0d]: key=%0d pulses=%0d unstable=%0d colbad=%0d, expected key=%0d",
                 idxs[j], fk, pulses, unst, colb, ek);
      else n_pass++;
      release_wait(lat, col_at, relp);
      n_checks++;
      if (lat < 0 || relp != 0)
        $display("FAIL star_hash_release[%0d]: latency=%0d pulses=%0d, expected key=10 and no pulse",
                 idxs[j], lat, relp);
      else n_pass++;
    end
  endtask

  task automatic test_multi_key();
    int pulses, fk, lat, relp;
    bit unst, colb;
    logic [2:0] col_at;
    // '7', '4' share column 0 (scanned first); '2' sits in column 1.
    pulse_reset();
    press_hold((12'b1 << 6) | (12'b1 << 3) | (12'b1 << 1), 40, pulses, fk, unst, colb);
    n_checks++;
    if (fk != 4 || pulses != 1 || unst || colb)
      $display("FAIL multi_key: key=%0d pulses=%0d unstable=%0d, expected key=4 pulses=1", fk, pulses, unst);
    else n_pass++;
    release_wait(lat, col_at, relp);
  endtask

  task automatic test_reset_mid_press();
    int pulses, fk;
    bit unst, colb, bad;
    pulse_reset();
    press_hold(12'b1 << 6, 40, pulses, fk, unst, colb);
    n_checks++;
    if (fk != 7 || pulses != 1)
      $display("FAIL midreset_press: key=%0d pulses=%0d, expected key=7 pulses=1", fk, pulses);
    else n_pass++;
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (key !== 4'd10 || col_drive !== 3'b110 || key_pulse !== 1'b0)
      $display("FAIL midreset_abort: key=%0d col=%b pulse=%b, expected key=10 col=110 pulse=0",
               key, col_drive, key_pulse);
    else n_pass++;
    pressed = '0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    bad = 0;
    repeat (40) begin
      @(negedge clock);
      if (key !== 4'd10 || key_pulse !== 1'b0) bad = 1;
    end
    n_checks++;
    if (bad) $display("FAIL midreset_after: key=%0d, expected key=10 and no pulse", key);
    else n_pass++;
  endtask

  task automatic test_random();
    int idx, hold, ek, pulses, fk, lat, relp;
    bit unst, colb;
    logic [2:0] col_at;
    pulse_reset();
    for (int it = 0; it < 12; it++) begin
      repeat ($urandom_range(0, 15)) @(negedge clock);
      idx  = $urandom_range(0, 11);
      hold = $urandom_range(40, 80);
      ek   = exp_key(idx);
      press_hold(12'b1 << idx, hold, pulses, fk, unst, colb);
      n_checks++;
      if (fk != ek || pulses != ((ek != 10) ? 1 : 0) || unst || colb)
        $display("FAIL random_press[%0d] idx=%0d: key=%0d pulses=%0d unstable=%0d colbad=%0d, expected key=%0d",
                 it, idx, fk, pulses, unst, colb, ek);
      else n_pass++;
      release_wait(lat, col_at, relp);
      n_checks++;
      if (lat < 0 || relp != 0 || (ek != 10 && (lat < DEB || col_at !== 3'b110)))
        $display("FAIL random_release[%0d]: latency=%0d col=%b pulses=%0d, expected key=10 no pulse",
                 it, lat, col_at, relp);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_press_latency();
    test_bounce();
    test_release_glitch();
    test_star_hash();
    test_multi_key();
    test_reset_mid_press();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
